// File: rtl/ros2_app_data_pkg.sv
// Shared types and helpers for the publisher application-data arbiter.
package ros2_app_data_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    STREAM  = 2'd2
  } arb_state_e;

  localparam int MAX_LEN_DEF = 64;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ros2_pub_app_data_arb.sv
// Publisher app-data req/grant/rel responder: snapshots the committed message
// into a shadow buffer and streams it byte-wise to the RTPS DATA serializer.
module ros2_pub_app_data_arb
  import ros2_app_data_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAX_LEN*8-1:0] app_data,
  input  logic [7:0]           app_data_len,
  input  logic                 app_data_req,
  input  logic                 app_data_rel,
  output logic                 app_data_grant,
  input  logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last,
  output logic [7:0]           tx_len,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 has_data
);

  localparam int RD_W = $clog2(MAX_LEN);
  localparam int IDX_W = RD_W + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             tx_pend;
  logic [7:0]       shadow [MAX_LEN];

  logic             start_stream;
  logic             empty_done;
  logic             beat;
  logic             last_beat;
  logic             capture;
  logic             stream_avail;

  // A zero-length commit is treated exactly like an empty buffer.
  assign stream_avail   = has_data && (tx_len != 8'd0);
  assign capture        = (state == GRANTED) && app_data_rel;
  assign app_data_grant = (state == GRANTED);
  assign tx_valid       = (state == STREAM);
  assign tx_data        = tx_valid ? shadow[idx[RD_W-1:0]] : 8'h00;
  assign tx_last        = tx_valid && (16'(idx) == (16'(tx_len) - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_stream = 1'b0;
    empty_done   = 1'b0;
    beat         = 1'b0;
    last_beat    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start || tx_pend) begin
          if (stream_avail) begin
            start_stream = 1'b1;
            state_nxt    = STREAM;
          end else begin
            empty_done = 1'b1;
            if (app_data_req) state_nxt = GRANTED;
          end
        end else if (app_data_req) begin
          state_nxt = GRANTED;
        end
      end
      GRANTED: begin
        if (app_data_rel) state_nxt = IDLE;
      end
      STREAM: begin
        if (tx_ready) begin
          beat = 1'b1;
          if (tx_last) begin
            last_beat = 1'b1;
            // Jump straight to GRANTED so a waiting request is granted alongside tx_done.
            state_nxt = app_data_req ? GRANTED : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      tx_pend  <= 1'b0;
      tx_len   <= 8'd0;
      has_data <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= empty_done || last_beat;
      if (start_stream)  idx <= '0;
      else if (beat)     idx <= idx + 1'b1;
      if (capture) begin
        tx_len   <= clamp_len(app_data_len, MAX_LEN_B);
        has_data <= 1'b1;
      end
      if ((state == GRANTED) && tx_start) tx_pend <= 1'b1;
      else if (state == IDLE)             tx_pend <= 1'b0;
      if (start_stream || ((state == GRANTED) && tx_start)) tx_busy <= 1'b1;
      else if (empty_done || last_beat)                     tx_busy <= 1'b0;
    end
  end

  // Shadow data path carries no reset; it is only meaningful once has_data is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < MAX_LEN; i++) shadow[i] <= app_data[8*i +: 8];
    end
  end

endmodule

// File: doc/ros2_pub_app_data_arb.md
# ros2_pub_app_data_arb

Responder side of the publisher application-data req/grant/rel handshake. The application raises `app_data_req`, drives message bytes while granted, and pulses `app_data_rel` to commit. The block snapshots the committed message into a shadow buffer and streams it byte-wise to the RTPS DATA serializer on request. It sits inside the ROS2 Ethernet core, between the application-facing publisher ports and the TX engine.

## Interface
- `MAX_LEN`, default 64: shadow buffer size in bytes; matches the configured maximum application data length.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `app_data` in MAX_LEN*8: message bytes; byte i is `app_data[8i+7:8i]`.
- `app_data_len` in 8: message length in bytes.
- `app_data_req` in 1: application requests buffer ownership.
- `app_data_rel` in 1: one-cycle commit/release pulse.
- `app_data_grant` out 1: application owns the buffer.
- `tx_start` in 1: one-cycle pulse from the TX engine requesting a stream.
- `tx_data` out 8: current byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: serializer accepts the byte.
- `tx_last` out 1: current beat is the final byte.
- `tx_len` out 8: committed length, stable while `tx_busy`.
- `tx_busy` out 1: stream is pending or in progress.
- `tx_done` out 1: one-cycle pulse at stream end.
- `has_data` out 1: the shadow buffer holds at least one committed message.

## Operation
- FSM states: IDLE, GRANTED, STREAM.
- **IDLE, `tx_start`=1:**
  - If `has_data`=1, go to STREAM.
  - If `has_data`=0, pulse `tx_done` next cycle with no beats.
- **IDLE, `app_data_req`=1 and no `tx_start`:** go to GRANTED.
- **IDLE, `tx_start` and `app_data_req` in the same cycle:** TX wins. The request stays pending and is granted after the stream ends.
- **GRANTED:**
  - `app_data_grant`=1.
  - On `app_data_rel`: shadow <= `app_data`, `tx_len` <= min(`app_data_len`, MAX_LEN), `has_data` <= 1, then return to IDLE.
  - Deasserting `app_data_req` without `rel` does not drop the grant. Grant ends only on `rel`.
- **`tx_start` while GRANTED:** latched into a `tx_pend` flag. After the `rel` capture, the FSM goes IDLE -> STREAM with the new data. A second `tx_start` while pending is absorbed.
- **`tx_start` while STREAM:** ignored.
- **`app_data_rel` outside GRANTED:** ignored.
- **STREAM:**
  - Byte index counter `idx` (width clog2(MAX_LEN)+1) starts at 0.
  - `tx_data` = shadow[idx] and `tx_valid`=1.
  - A beat occurs on `tx_valid`&`tx_ready`; `idx` increments on each beat.
  - `tx_last` = (`idx` == `tx_len`-1).
  - The beat with `tx_last` set returns the FSM to IDLE.
- **Committed length 0:** behaves as `has_data`=0, i.e. `tx_done` with no beats.
- **Clamp:** `app_data_len` > MAX_LEN is clamped to MAX_LEN.
- Shadow contents are never modified while STREAM.
- **Reset values:** all outputs 0, FSM IDLE, `tx_pend`=0. Shadow contents need no reset.
- **Reset mid-GRANTED or mid-STREAM:** aborts immediately. There is no `tx_done` and no capture.

## Timing
- `app_data_grant` rises 1 cycle after the `req` sample in IDLE.
- `app_data_grant` falls the cycle after `rel` is sampled.
- Captured data is visible to the stream on the cycle after `rel`.
- **`tx_start` -> first `tx_valid`:** 1 cycle when IDLE with data.
- **Pending path:** `tx_valid` asserts 2 cycles after `rel` (capture, then IDLE -> STREAM).
- **Stream throughput:** one byte per cycle with `tx_ready` held high. An N-byte stream occupies N cycles of `tx_valid`.
- **Backpressure:** `tx_data`, `tx_valid` and `tx_last` hold steady while `tx_ready`=0.
- **`tx_done`:** pulses 1 cycle after the last beat; `tx_busy` falls in the same cycle.
- **`tx_busy`:** high from the cycle after `tx_start` (or after pending latch) until `tx_done`.
- **Earliest re-grant:** a pending `req` is granted on the cycle `tx_done` pulses.

## Structure
- Package `ros2_app_data_pkg` holds:
  - the FSM state enum (IDLE/GRANTED/STREAM);
  - the default MAX_LEN constant;
  - a length clamp function.
- No sub-module: a single module of roughly 150–250 lines.
- The shadow is a register array, so MAX_LEN*8 flops. The TX-side read is a mux on `idx`.

## Test plan
- **Basic commit and stream:**
  - Stimulus: `req`; after grant drive `app_data`="Hello" (bytes 0x48,0x65,0x6C,0x6C,0x6F), len=5, pulse `rel`; then `tx_start` with `tx_ready`=1.
  - Response: exactly 5 beats in order, `tx_last` on 0x6F, `tx_done` 1 cycle later, `has_data`=1.
- **Empty start:** `tx_start` after reset -> no `tx_valid`, `tx_done` pulse next cycle, `has_data`=0.
- **Collision in IDLE:**
  - Stimulus: `tx_start` and `req` in the same cycle with a 3-byte message committed.
  - Response: 3-byte stream first; grant asserts at the `tx_done` cycle.
- **Start during grant:**
  - Stimulus: `tx_start` while GRANTED, then `rel` with len=2 of {0xAA,0xBB}.
  - Response: `tx_valid` 2 cycles after `rel`, beats 0xAA, 0xBB.
- **Backpressure and clamp:**
  - Stimulus: `app_data_len`=200 with MAX_LEN=64; toggle `tx_ready` every other cycle.
  - Response: `tx_len`=64, 64 beats, data held stable on stall cycles.
- **Reset mid-stream:** assert `rst` at beat 10 of 20 -> next cycle all outputs 0, no `tx_done`. The next `tx_start` behaves as empty (`has_data`=0).
